muldiv_seq: RTL

//  Multi-cycle unsigned MULTU/DIVU sequencer for the pipelined MIPS EX stage.

---
 rtl/mips_alu_pkg.sv | 11 +
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU operation codes, used by the EX stage and any block that borrows the ALU.
package mips_alu_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;
  localparam logic [2:0] ALU_NOP  = 3'b000;
endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bus of the MULTU/DIVU sequencer plus its borrowed-ALU port.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic            is_div;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;

  modport slave (
    input  start, is_div, src_a, src_b, alu_y,
    output busy, done, hi, lo, alu_op, alu_a, alu_b
  );

  modport master (
    output start, is_div, src_a, src_b, alu_y,
    input  busy, done, hi, lo, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU: two ALU phases per bit on the shared ALU, 64 phases per op.
// hi/lo are only updated when an operation completes; the pipeline stalls while busy.
module muldiv_seq
  import mips_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PH_A = 2'd1;
  localparam logic [1:0] S_PH_B = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_whi;
  logic [XLEN-1:0] r_wlo;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_tmp;
  logic            r_msb;
  logic            r_lt;
  logic            r_mode;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic [2:0]      w_alu_op;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_whi_nxt;
  logic [XLEN-1:0] w_wlo_nxt;
  logic            w_last;

  assign w_sh   = {r_whi[XLEN-2:0], r_wlo[XLEN-1]};
  assign w_last = (r_count == CNT_W'(XLEN - 1));

  always_comb begin
    w_alu_op = ALU_NOP;
    w_alu_a  = '0;
    w_alu_b  = '0;
    case (r_state)
      S_PH_A: begin
        if (r_mode) begin
          w_alu_op = ALU_SLTU;
          w_alu_a  = w_sh;
          w_alu_b  = r_opnd;
        end else begin
          w_alu_op = ALU_ADD;
          w_alu_a  = r_whi;
          w_alu_b  = r_wlo[0] ? r_opnd : '0;
        end
      end
      S_PH_B: begin
        if (r_mode) begin
          w_alu_op = ALU_SUB;
          w_alu_a  = r_whi;
          w_alu_b  = r_opnd;
        end else begin
          w_alu_op = ALU_SLTU;
          w_alu_a  = r_tmp;
          w_alu_b  = r_whi;
        end
      end
      default: ;
    endcase
  end

  // Second-phase update; the sltu carry recovers bit 32 of the partial sum.
  always_comb begin
    w_whi_nxt = r_whi;
    w_wlo_nxt = r_wlo;
    if (r_mode) begin
      if (r_msb || !r_lt) begin
        w_whi_nxt = bus.alu_y;
        w_wlo_nxt = {r_wlo[XLEN-1:1], 1'b1};
      end
    end else begin
      w_whi_nxt = {bus.alu_y[0], r_tmp[XLEN-1:1]};
      w_wlo_nxt = {r_tmp[0], r_wlo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_whi   <= '0;
      r_wlo   <= '0;
      r_opnd  <= '0;
      r_tmp   <= '0;
      r_msb   <= 1'b0;
      r_lt    <= 1'b0;
      r_mode  <= 1'b0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_whi   <= '0;
            r_wlo   <= bus.src_a;
            r_opnd  <= bus.src_b;
            r_mode  <= bus.is_div;
            r_count <= '0;
            r_state <= S_PH_A;
          end
        end
        S_PH_A: begin
          if (r_mode) begin
            r_msb <= r_whi[XLEN-1];
            r_lt  <= bus.alu_y[0];
            r_whi <= w_sh;
            r_wlo <= {r_wlo[XLEN-2:0], 1'b0};
          end else begin
            r_tmp <= bus.alu_y;
          end
          r_state <= S_PH_B;
        end
        S_PH_B: begin
          r_whi   <= w_whi_nxt;
          r_wlo   <= w_wlo_nxt;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_hi    <= w_whi_nxt;
            r_lo    <= w_wlo_nxt;
            r_state <= S_DONE;
          end else begin
            r_state <= S_PH_A;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.alu_op = w_alu_op;
  assign bus.alu_a  = w_alu_a;
  assign bus.alu_b  = w_alu_b;

endmodule
